sbus_initiator: RTL and testbench
=================================

// Module: sbus_initiator
// PURPOSE
//  Initiator (master) for the team's simple valid/ready peripheral bus: takes
//  single or burst read/write commands, drives valid/addr/wdata/wstrb, waits
//  for the one-cycle ready pulse and returns rdata on a response channel.
//  Sits between LA/management-side command logic and bus responders such as counters.
//  Includes a per-beat timeout so a dead responder cannot hang the initiator.
// PARAMETERS
//  DW         32   data width (wdata/rdata), multiple of 8
//  AW         32   address width
//  LEN_W      8    width of burst length field (beats = cmd_len+1)
//  ADDR_STEP  4    address increment between beats of a burst
//  TIMEOUT    255  cycles to wait for ready per beat; 0 = timeout disabled
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when cmd_valid&cmd_ready
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_addr   in   AW      start address
//  cmd_wdata  in   DW      write data (same value for every beat)
//  cmd_wstrb  in   DW/8    byte strobes for writes; ignored for reads
//  cmd_len    in   LEN_W   beats minus one
//  rsp_valid  out  1       response beat available
//  rsp_ready  in   1       response beat consumed when rsp_valid&rsp_ready
//  rsp_rdata  out  DW      rdata captured from bus (reads and writes)
//  rsp_err    out  1       beat timed out; burst aborted
//  rsp_last   out  1       final beat of the command (normal or aborted)
//  busy       out  1       state != IDLE
//  valid      out  1       bus request
//  addr       out  AW      bus address
//  wdata      out  DW      bus write data
//  wstrb      out  DW/8    bus strobes; all-zero = read
//  ready      in   1       responder one-cycle completion pulse
//  rdata      in   DW      responder data, valid in the ready cycle
// BEHAVIOUR
//  Reset: state IDLE; valid, rsp_valid, rsp_err, rsp_last, busy = 0; addr, wdata,
//   wstrb, rsp_rdata = 0; cmd_ready = 1 once reset deasserts.
//  All outputs registered except cmd_ready = (state==IDLE) and busy = !cmd_ready.
//  States: IDLE -> ACCESS -> RESP -> (ACCESS | IDLE).
//  IDLE: on cmd_valid latch addr/wdata/wstrb (wstrb forced 0 if !cmd_write),
//   beats_left=cmd_len, clear timer; next state ACCESS, valid=1 from next cycle.
//  ACCESS: valid held high, addr/wdata/wstrb stable. On ready=1: valid cleared
//   at that same edge (responder re-triggers if valid seen high after ready),
//   rsp_rdata<=rdata, rsp_err=0, rsp_last=(beats_left==0), go RESP.
//  Timer counts cycles in ACCESS; if TIMEOUT!=0 and timer==TIMEOUT with no
//   ready: valid=0, rsp_err=1, rsp_last=1, rsp_rdata=0, remaining beats dropped.
//   ready and timeout in same cycle: ready wins (normal completion).
//  RESP: rsp_valid=1, held with data stable until rsp_ready. On accept: if
//   rsp_last, go IDLE; else beats_left-=1, addr+=ADDR_STEP (mod 2^AW), timer=0,
//   go ACCESS with valid=1 next cycle.
//  ready while valid=0 (late pulse after timeout) ignored.
//  Latency: cmd accept edge T -> valid at T+1 -> responder ready earliest T+2
//   -> rsp_valid at T+3; next burst beat valid the cycle after rsp accept.
//  Reset mid-operation: valid and rsp_valid drop at the reset edge; command lost.
//  cmd_len = 2^LEN_W-1 gives 2^LEN_W beats; beat counter never wraps.
// TESTING
//  1 write addr=0x10 wdata=0x1234_5678 wstrb=0xF len=0 -> one valid pulse,
//    wstrb=0xF, rsp_last=1, rsp_err=0, rsp_rdata = responder old value.
//  2 read addr=0x20 len=0, responder rdata=0xCAFE_F00D -> wstrb=0,
//    rsp_rdata=0xCAFE_F00D, valid low the cycle after ready.
//  3 read len=3 addr=0xFFFF_FFF8 -> addrs FFFF_FFF8,FFFF_FFFC,0,4; rsp_last
//    only on 4th beat; exactly 4 ready pulses consumed.
//  4 TIMEOUT=8, responder never answers, len=2 -> valid high 8 cycles then low,
//    one rsp with err=1,last=1; late ready pulse ignored; back to IDLE.
//  5 rsp_ready held low 10 cycles mid-burst -> rsp data stable, valid stays 0,
//    no extra bus access until accepted.
//  6 reset asserted during ACCESS of beat 2 of 4 -> valid=0, rsp_valid=0 after
//    edge; cmd_ready=1 after reset deasserts; new command runs cleanly.

Source files
------------

// File: rtl/sbus_initiator_if.sv
// sbus_initiator_if: groups the command, response and peripheral-bus signals
// of the simple valid/ready bus initiator.
//   master : initiator view (drives cmd_ready, rsp_*, busy, valid/addr/wdata/wstrb)
//   slave  : environment view (command source, response sink, bus responder)
interface sbus_initiator_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned LEN_W = 8
);
  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;
  logic [DW/8-1:0]  cmd_wstrb;
  logic [LEN_W-1:0] cmd_len;
  // response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             rsp_last;
  logic             busy;
  // peripheral bus
  logic             valid;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic [DW/8-1:0]  wstrb;
  logic             ready;
  logic [DW-1:0]    rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_len,
           rsp_ready, ready, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_last, busy,
           valid, addr, wdata, wstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_len,
           rsp_ready, ready, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_last, busy,
           valid, addr, wdata, wstrb
  );
endinterface

// File: rtl/sbus_initiator.sv
// sbus_initiator: bus master for the simple valid/ready peripheral bus.
// Accepts single or burst read/write commands, runs one bus access per beat,
// waits for the responder's one-cycle ready pulse and returns each beat on
// the response channel. A per-beat timeout aborts the burst if no ready comes.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : sbus_initiator_if.master (command, response and bus signals)
module sbus_initiator #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  sbus_initiator_if.master   bus
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW/8-1:0]  r_wstrb;
  logic [LEN_W-1:0] r_beats_left;
  logic [TW-1:0]    r_timer;
  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_rsp_last;

  logic [TW-1:0]    w_timer_inc;
  logic             w_timeout;

  // The timer holds the number of ACCESS cycles already completed, so the
  // abort fires at the edge ending the TIMEOUT-th cycle with valid high.
  always_comb begin
    w_timer_inc = r_timer + TW'(1);
    w_timeout   = (TIMEOUT != 0) && (w_timer_inc == TW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_beats_left <= '0;
      r_timer      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_addr       <= bus.cmd_addr;
            r_wdata      <= bus.cmd_wdata;
            r_wstrb      <= bus.cmd_write ? bus.cmd_wstrb : '0;
            r_beats_left <= bus.cmd_len;
            r_timer      <= '0;
            r_valid      <= 1'b1;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // ready takes priority over a timeout expiring in the same cycle
          if (bus.ready) begin
            r_valid     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= bus.rdata;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= (r_beats_left == '0);
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_valid     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_last  <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_last) begin
              r_state <= S_IDLE;
            end else begin
              r_beats_left <= r_beats_left - LEN_W'(1);
              r_addr       <= r_addr + AW'(ADDR_STEP);
              r_timer      <= '0;
              r_valid      <= 1'b1;
              r_state      <= S_ACCESS;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.valid     = r_valid;
  assign bus.addr      = r_addr;
  assign bus.wdata     = r_wdata;
  assign bus.wstrb     = r_wstrb;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_sbus_initiator.sv
module tb_sbus_initiator;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned TMO   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sbus_initiator_if #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) bus ();

  sbus_initiator #(
    .DW(DW), .AW(AW), .LEN_W(LEN_W), .ADDR_STEP(4), .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rd;
    logic [3:0]  exp_strb;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Offer a command at a negedge; valid must be high one cycle later.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [7:0] len);
    chk("cmd_ready before cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_wstrb = st;
    bus.cmd_len   = len;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("valid after accept", 32'(bus.valid), 32'd1);
    chk("busy after accept", 32'(bus.busy), 32'd1);
    chk("cmd_ready after accept", 32'(bus.cmd_ready), 32'd0);
  endtask

  // One beat: responder answers a cycle after seeing valid; response may be
  // held off for 'stall' cycles before it is accepted.
  task automatic beat(input string tag, input logic [31:0] ea, input logic [31:0] ew,
                      input logic [3:0] es, input logic [31:0] rd, input logic el,
                      input int stall);
    int t;
    int extra;
    t = 0;
    while (bus.valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " valid"}, 32'(bus.valid), 32'd1);
    chk({tag, " addr"}, bus.addr, ea);
    chk({tag, " wdata"}, bus.wdata, ew);
    chk({tag, " wstrb"}, 32'(bus.wstrb), 32'(es));
    @(negedge clk);
    chk({tag, " valid held"}, 32'(bus.valid), 32'd1);
    bus.ready = 1'b1;
    bus.rdata = rd;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.rdata = '0;
    chk({tag, " valid low after ready"}, 32'(bus.valid), 32'd0);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, rd);
    chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, " rsp_last"}, 32'(bus.rsp_last), 32'(el));
    extra = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) extra++;
    end
    if (stall > 0) begin
      chk({tag, " stall valid cycles"}, 32'(extra), 32'd0);
      chk({tag, " stall rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " stall rsp_rdata"}, bus.rsp_rdata, rd);
      chk({tag, " stall rsp_last"}, 32'(bus.rsp_last), 32'(el));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, " rsp_valid after accept"}, 32'(bus.rsp_valid), 32'd0);
    if (el) chk({tag, " cmd_ready after last"}, 32'(bus.cmd_ready), 32'd1);
    else    chk({tag, " next beat valid"}, 32'(bus.valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   cnt;
    int   vcount;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 4'hF};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h5555_AAAA, 4'hF, 32'hCAFE_F00D, 4'h0};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_0001, 4'h5, 32'h0000_0000, 4'h5};
    vecs[3] = '{1'b0, 32'h0000_0300, 32'h0000_0000, 4'hA, 32'hFFFF_FFFF, 4'h0};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.cmd_len   = '0;
    bus.rsp_ready = 1'b0;
    bus.ready     = 1'b0;
    bus.rdata     = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset valid", 32'(bus.valid), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset rsp_last", 32'(bus.rsp_last), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset addr", bus.addr, 32'd0);
    chk("reset wdata", bus.wdata, 32'd0);
    chk("reset wstrb", 32'(bus.wstrb), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready after reset", 32'(bus.cmd_ready), 32'd1);

    // single-beat table
    for (int v = 0; v < 4; v++) begin
      issue(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, 8'd0);
      beat($sformatf("vec%0d", v), vecs[v].addr, vecs[v].wdata, vecs[v].exp_strb,
           vecs[v].rd, 1'b1, 0);
    end

    // read burst wrapping the address space
    issue(1'b0, 32'hFFFF_FFF8, 32'h0, 4'hF, 8'd3);
    beat("wrap b0", 32'hFFFF_FFF8, 32'h0, 4'h0, 32'h0000_0100, 1'b0, 0);
    beat("wrap b1", 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0000_0101, 1'b0, 0);
    beat("wrap b2", 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0102, 1'b0, 0);
    beat("wrap b3", 32'h0000_0004, 32'h0, 4'h0, 32'h0000_0103, 1'b1, 0);
    vcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.valid === 1'b1) vcount++;
    end
    chk("wrap no fifth access", 32'(vcount), 32'd0);

    // dead responder: timeout aborts the burst
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 8'd2);
    cnt = 0;
    while (bus.valid === 1'b1 && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout valid cycles", 32'(cnt), 32'(TMO));
    chk("timeout rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("timeout rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("timeout rsp_last", 32'(bus.rsp_last), 32'd1);
    chk("timeout rsp_rdata", bus.rsp_rdata, 32'd0);
    bus.ready = 1'b1;
    bus.rdata = 32'h7777_7777;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.rdata = '0;
    chk("late ready rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("late ready rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("late ready valid", 32'(bus.valid), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("timeout back to idle", 32'(bus.cmd_ready), 32'd1);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    @(negedge clk);
    chk("idle ready ignored valid", 32'(bus.valid), 32'd0);
    chk("idle ready ignored rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // ready in the last cycle before timeout wins
    issue(1'b0, 32'h0000_0050, 32'h0, 4'h0, 8'd0);
    repeat (TMO - 1) @(negedge clk);
    chk("edge valid still high", 32'(bus.valid), 32'd1);
    bus.ready = 1'b1;
    bus.rdata = 32'h1357_9BDF;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.rdata = '0;
    chk("edge rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("edge rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("edge rsp_rdata", bus.rsp_rdata, 32'h1357_9BDF);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // response back-pressure mid-burst
    issue(1'b1, 32'h0000_0200, 32'hBEEF_0000, 4'h3, 8'd2);
    beat("stall b0", 32'h0000_0200, 32'hBEEF_0000, 4'h3, 32'h11, 1'b0, 0);
    beat("stall b1", 32'h0000_0204, 32'hBEEF_0000, 4'h3, 32'h22, 1'b0, 10);
    beat("stall b2", 32'h0000_0208, 32'hBEEF_0000, 4'h3, 32'h33, 1'b1, 0);

    // reset during beat 2 of 4
    issue(1'b0, 32'h0000_0080, 32'h0, 4'h0, 8'd3);
    beat("rst b0", 32'h0000_0080, 32'h0, 4'h0, 32'h44, 1'b0, 0);
    chk("rst b1 addr", bus.addr, 32'h0000_0084);
    reset = 1'b1;
    @(negedge clk);
    chk("rst valid", 32'(bus.valid), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst addr", bus.addr, 32'd0);
    issue(1'b1, 32'h0000_0090, 32'h0BAD_F00D, 4'hC, 8'd0);
    beat("post rst", 32'h0000_0090, 32'h0BAD_F00D, 4'hC, 32'h55, 1'b1, 0);

    // maximum burst length: 256 beats, counter must not wrap
    issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, 8'hFF);
    for (int b = 0; b < 256; b++) begin
      beat($sformatf("max b%0d", b), 32'h0000_1000 + 32'(b) * 32'd4, 32'h0, 4'h0,
           32'(b) ^ 32'hA000_0000, (b == 255), 0);
    end
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.valid === 1'b1) vcount++;
    end
    chk("max no extra beat", 32'(vcount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
